serial_logic_ctrl: RTL
======================

SERIAL_LOGIC_CTRL -- requirements
Module: serial_logic_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation, sampled on rising edge.
REQ-005 The block SHALL have port op, input, 3 bits: operation code, where op[0] maps to s0, op[1] to s1 and op[2] to s2.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-007 The block SHALL have ports s0, s1 and s2, output, 1 bit each: select lines to the downstream 1-bit logic unit.
REQ-008 The block SHALL have ports a_bit and b_bit, output, 1 bit each: serial operand bits to the logic unit.
REQ-009 The block SHALL have port e_bit, input, 1 bit: combinational result from the logic unit for the current a_bit, b_bit and select.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 The block SHALL have port result, output, WIDTH bits: assembled result.

Function
REQ-013 Op encoding SHALL be fixed as: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A, 7 BUF A.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch op, a and b, clear the bit counter and result register, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-017 In each RUN cycle with counter i, the block SHALL drive a_bit=a_reg[i], b_bit=b_reg[i] and {s2,s1,s0}=op_reg, then capture e_bit into result_reg[i] at the next edge; capture is same-cycle because the logic unit is combinational.
REQ-018 The counter SHALL increment once per RUN cycle, LSB first; when i=WIDTH-1 the block SHALL go to DONE and the counter SHALL wrap to 0.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 Latency: for start sampled at edge 0, RUN SHALL occupy cycles 1..WIDTH and done SHALL be high in cycle WIDTH+1.
REQ-022 result SHALL update only on RUN captures and SHALL hold its final value from DONE until the next accepted start.
REQ-023 start SHALL be ignored in RUN and DONE, and latched operands SHALL NOT change.
REQ-024 In IDLE and DONE, a_bit and b_bit SHALL be 0 and s2..s0 SHALL hold op_reg.
REQ-025 Changes on a, b or op after acceptance SHALL have no effect on the running operation.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set state=IDLE, counter=0, op_reg=0, a_reg=0, b_reg=0, result=0, busy=0, done=0, s0=s1=s2=0 and a_bit=b_bit=0.
REQ-027 rst SHALL take priority over start.
REQ-028 rst during RUN or DONE SHALL abort the operation, emit no done pulse and leave result cleared.

Structure
REQ-029 The op-code constants and FSM state encoding SHALL reside in a shared package/include, logic_ops_pkg.
REQ-030 One sub-module, serial_shift_reg (WIDTH-bit parallel-load, bit-indexed read/write), is natural for the operand and result registers.
REQ-031 The 1-bit logic unit SHALL be external to the block and connected via s0..s2, a_bit, b_bit and e_bit.

Verification
REQ-032 The bench SHALL cover: op=0, a=8'hF0, b=8'hCC, start at edge 0 -> busy in cycles 1..9, done only in cycle 9, result=8'hC0.
REQ-033 The bench SHALL cover: op=6, a=8'hA5, b=8'h00 -> result=8'h5A; op=7, same operands -> result=8'hA5.
REQ-034 The bench SHALL cover: op=2, a=8'hFF, b=8'h0F, with start re-asserted and a changed to 8'h00 in cycle 3 -> result=8'hF0 and a single done pulse.
REQ-035 The bench SHALL cover: reset asserted in cycle 4 of RUN (op=1, a=8'h01, b=8'h80) -> busy=0, done never asserted, result=8'h00; a subsequent start completes normally with result=8'h81.
REQ-036 The bench SHALL cover: start held high continuously -> operations back-to-back with one IDLE cycle between done and the next RUN.
REQ-037 The bench SHALL cover: all 8 ops with a=8'hAA, b=8'hCC against a golden model -> 8'h88, EE, 66, 99, 77, 11, 55, AA.

Source files
------------

// File: rtl/logic_ops_pkg.sv
// Shared op-code and FSM state encodings for the serial logic controller.
// Also provides the counter index width helper.
package logic_ops_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_NOTA = 3'd6,
        OP_BUFA = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// WIDTH-bit register with parallel load and single-bit indexed write.
// Load has priority over the bit write.
module serial_shift_reg
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic [IW-1:0]    idx,
    input  logic             wbit,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (wr) begin
            q[idx] <= wbit;
        end
    end

endmodule

// File: rtl/serial_logic_ctrl.sv
// Bit-serial sequencer for an external 1-bit logic unit.
// Operands go out LSB first; the unit's result bit is captured the same cycle.
module serial_logic_ctrl
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             a_bit,
    output logic             b_bit,
    input  logic             e_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_e           state;
    state_e           nstate;
    logic [IW-1:0]    cnt;
    op_e              op_reg;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             accept;
    logic             run;

    assign accept = (state == ST_IDLE) && start;
    assign run    = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE: if (start) nstate = ST_RUN;
            ST_RUN:  if (cnt == LAST) nstate = ST_DONE;
            ST_DONE: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE);
        a_bit = run ? a_q[cnt] : 1'b0;
        b_bit = run ? b_q[cnt] : 1'b0;
        s0    = op_reg[0];
        s1    = op_reg[1];
        s2    = op_reg[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_reg <= OP_AND;
        end else if (accept) begin
            cnt    <= '0;
            op_reg <= op_e'(op);
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + IW'(1);
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_a (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .din  (a),
        .wr   (1'b0),
        .idx  (cnt),
        .wbit (1'b0),
        .q    (a_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .din  (b),
        .wr   (1'b0),
        .idx  (cnt),
        .wbit (1'b0),
        .q    (b_q)
    );

    // Result is cleared on accept and filled one bit per RUN cycle.
    serial_shift_reg #(.WIDTH(WIDTH)) u_res (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .din  ('0),
        .wr   (run),
        .idx  (cnt),
        .wbit (e_bit),
        .q    (result)
    );

endmodule
